// File: rtl/busmux_pkg.sv
// busmux_pkg: definitions shared by the busmux register-bus blocks.
//   BUS_ADDRW   width of the register-bus address
//   CNT_W       width of the read-latency down-counter (RD_LAT up to 15)
//   *_ENC       state encodings, 3 bits
//   busmux_state_e  initiator FSM state type built on those encodings
package busmux_pkg;

  localparam int BUS_ADDRW = 8;
  localparam int CNT_W     = 4;

  localparam logic [2:0] ST_IDLE_ENC = 3'd0;
  localparam logic [2:0] ST_WR_ENC   = 3'd1;
  localparam logic [2:0] ST_RD_ENC   = 3'd2;
  localparam logic [2:0] ST_RBK_ENC  = 3'd3;
  localparam logic [2:0] ST_RSP_ENC  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_WR   = ST_WR_ENC,
    ST_RD   = ST_RD_ENC,
    ST_RBK  = ST_RBK_ENC,
    ST_RSP  = ST_RSP_ENC
  } busmux_state_e;

endpackage

// File: rtl/busmux_initiator.sv
// busmux_initiator: bus master for the busmux register bus. Takes one write or
// read command at a time on a valid/ready port, runs it as a single bus access
// against a slave with registered read data (RD_LAT cycles), and returns one
// response per command on a valid/ready port.
//
// Parameters
//   DATAW    data width of bus and command
//   RD_LAT   slave read latency in cycles, 1..15
//
// Ports
//   i_clk, i_rst_n             clock (rising edge), async active-low reset
//   i_cmd_valid/o_cmd_ready    command handshake; ready only in IDLE
//   i_cmd_we/addr/data         command: 1 = write; write data ignored on reads
//   o_rsp_valid/i_rsp_ready    response handshake
//   o_rsp_data, o_rsp_err      read data (or write-data echo), readback error
//   o_bus_we/addr/data         slave write enable, address, write data
//   i_bus_data                 slave registered read data
//   o_busy                     high whenever the FSM is not in IDLE
//
// Build option
//   BUSMUX_INITIATOR_RDBK_EN   when defined, every write is followed by a
//                              readback of the same address; o_rsp_err flags a
//                              mismatch. When undefined, o_rsp_err is tied 0.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready=1
// WR    | single bus write cycle, bus_we=1
// RD    | read in flight, counter running down from RD_LAT
// RBK   | readback of the just-written address (RDBK build only)
// RSP   | response presented, waiting for rsp_ready
module busmux_initiator
  import busmux_pkg::*;
#(
  parameter int DATAW  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_cmd_valid,
  output logic                 o_cmd_ready,
  input  logic                 i_cmd_we,
  input  logic [BUS_ADDRW-1:0] i_cmd_addr,
  input  logic [DATAW-1:0]     i_cmd_data,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [DATAW-1:0]     o_rsp_data,
  output logic                 o_rsp_err,
  output logic                 o_bus_we,
  output logic [BUS_ADDRW-1:0] o_bus_addr,
  output logic [DATAW-1:0]     o_bus_data,
  input  logic [DATAW-1:0]     i_bus_data,
  output logic                 o_busy
);

  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);

  busmux_state_e        state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BUS_ADDRW-1:0] bus_addr_q;
  logic [DATAW-1:0]     bus_data_q;
  logic [DATAW-1:0]     rsp_data_q;
  logic                 accept;
  logic                 rd_sample;

  assign accept = i_cmd_valid && (state_q == ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rd_sample = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          if (i_cmd_we) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
            cnt_d   = RD_LAT_C;
          end
        end
      end
      ST_WR: begin
`ifdef BUSMUX_INITIATOR_RDBK_EN
        state_d = ST_RBK;
        cnt_d   = RD_LAT_C;
`else
        state_d = ST_RSP;
`endif
      end
`ifdef BUSMUX_INITIATOR_RDBK_EN
      ST_RBK,
`endif
      ST_RD: begin
        // Slave data is valid once the counter has run out; RD_LAT+1 cycles total.
        if (cnt_q == '0) begin
          rd_sample = 1'b1;
          state_d   = ST_RSP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RSP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Bus address/data are loaded for every accepted command (reads included) and
  // then held until the next accept, so the slave sees a stable address in
  // IDLE and RSP as well.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus_addr_q <= '0;
      bus_data_q <= '0;
      rsp_data_q <= '0;
    end else begin
      if (accept) begin
        bus_addr_q <= i_cmd_addr;
        bus_data_q <= i_cmd_data;
        if (i_cmd_we) rsp_data_q <= i_cmd_data;
      end
      // A readback sample only feeds the error flag; the response keeps the
      // write-data echo.
      if (rd_sample && (state_q == ST_RD)) rsp_data_q <= i_bus_data;
    end
  end

`ifdef BUSMUX_INITIATOR_RDBK_EN
  logic rsp_err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_err_q <= 1'b0;
    end else if (accept) begin
      rsp_err_q <= 1'b0;
    end else if (rd_sample && (state_q == ST_RBK)) begin
      rsp_err_q <= (i_bus_data != bus_data_q);
    end
  end

  assign o_rsp_err = rsp_err_q;
`else
  assign o_rsp_err = 1'b0;
`endif

  assign o_cmd_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_bus_we    = (state_q == ST_WR);
  assign o_rsp_valid = (state_q == ST_RSP);
  assign o_bus_addr  = bus_addr_q;
  assign o_bus_data  = bus_data_q;
  assign o_rsp_data  = rsp_data_q;

endmodule
